// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl: single-outstanding AXI4-Lite master turning cmd_* requests into bus transactions.
// Define AXIL_TIMEOUT_EN to abort a bus phase after TIMEOUT cycles with rsp_err=1.
module axi_lite_master_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [3:0]  ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic        RVALID,
  output logic        RREADY
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_RSP} state_t;
  state_t state, state_n, succ;
  logic [3:0] addr_q, wstrb_q;
  logic [31:0] wdata_q, rdata_q;
  logic aw_done, w_done, accept, aw_hs, w_hs, fin, abort;
  assign accept = cmd_valid & cmd_ready;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs = WVALID & WREADY;
  // fin: the current state's exit condition holds; succ: where it goes when it does
  always_comb begin
    fin = 1'b1;
    succ = S_IDLE;
    case (state)
      S_IDLE: begin
        fin = accept;
        succ = cmd_write ? S_WRITE : S_RADDR;
      end
      S_WRITE: begin
        fin = (aw_done | aw_hs) & (w_done | w_hs);
        succ = S_WRESP;
      end
      S_WRESP: begin
        fin = BVALID;
        succ = S_RSP;
      end
      S_RADDR: begin
        fin = ARREADY;
        succ = S_RDATA;
      end
      S_RDATA: begin
        fin = RVALID;
        succ = S_RSP;
      end
      default: begin
        fin = 1'b1;
        succ = S_IDLE;
      end
    endcase
    state_n = fin ? succ : abort ? S_RSP : state;
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      aw_done <= (state == S_WRITE) && (state_n == S_WRITE) && (aw_done | aw_hs);
      w_done <= (state == S_WRITE) && (state_n == S_WRITE) && (w_done | w_hs);
      if (state == S_RDATA && RVALID) rdata_q <= RDATA;
    end
  end
`ifdef AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic err_q;
  assign abort = (state != S_IDLE) && (state != S_RSP) && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= (state_n != state || state == S_IDLE || state == S_RSP) ? '0 : cnt + 1'b1;
      err_q <= abort & ~fin;
    end
  end
  assign rsp_err = err_q;
`else
  assign abort = 1'b0;
  assign rsp_err = (TIMEOUT < 0);
`endif
  assign cmd_ready = (state == S_IDLE) & ARESETn;
  assign rsp_valid = state == S_RSP;
  assign rsp_rdata = rdata_q;
  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign WDATA = wdata_q;
  assign WSTRB = wstrb_q;
  assign AWVALID = (state == S_WRITE) & ~aw_done;
  assign WVALID = (state == S_WRITE) & ~w_done;
  assign BREADY = state == S_WRESP;
  assign ARVALID = state == S_RADDR;
  assign RREADY = state == S_RDATA;
endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// tb_axi_lite_master_ctrl: directed bench with a delay-programmable AXI-Lite slave and a response scoreboard.
module tb_axi_lite_master_ctrl;
  logic ACLK = 1'b0, ARESETn;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_err;
  logic [3:0] cmd_addr, cmd_wstrb, AWADDR, WSTRB, ARADDR;
  logic [31:0] cmd_wdata, rsp_rdata, WDATA, RDATA;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;
  int lat, n_aw, n_w, n_b, n_r, n_rsp;
  logic [3:0] seen_aw, seen_ar, seen_ws;
  logic [31:0] seen_wd, model;
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit aw_never;
  logic [31:0] r_data;
  int aw_c, w_c, b_c, ar_c, r_c;
  bit aw_got, w_got, b_pend, r_pend;

  axi_lite_master_ctrl #(.TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // slave decides its inputs mid-cycle from the master's current outputs; a handshake takes effect at the next rising edge
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
      RDATA = '0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    end else begin
      BVALID = b_pend && b_c >= b_dly;
      if (BVALID && BREADY) begin b_pend = 0; b_c = 0; end else if (b_pend) b_c++;
      RVALID = r_pend && r_c >= r_dly;
      RDATA = RVALID ? r_data : '0;
      if (RVALID && RREADY) begin r_pend = 0; r_c = 0; end else if (r_pend) r_c++;
      AWREADY = AWVALID && !aw_never && aw_c >= aw_dly;
      aw_c = (AWVALID && !AWREADY) ? aw_c + 1 : 0;
      WREADY = WVALID && w_c >= w_dly;
      w_c = (WVALID && !WREADY) ? w_c + 1 : 0;
      ARREADY = ARVALID && ar_c >= ar_dly;
      ar_c = (ARVALID && !ARREADY) ? ar_c + 1 : 0;
      if (AWVALID && AWREADY) aw_got = 1;
      if (WVALID && WREADY) w_got = 1;
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (ARVALID && ARREADY) r_pend = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a falling edge; returns just after the accepting rising edge
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic err);
    int n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    if (!wr) r_data = d;
    if (!wr && !err) model = d;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    chk("accept", cmd_ready, 1);
    sb.push_back({model, err});
    lat = 1; n_aw = 0; n_w = 0; n_b = 0; n_r = 0;
    seen_aw = 'x; seen_ar = 'x; seen_wd = 'x; seen_ws = 'x;
    @(posedge ACLK);
    #1 cmd_valid = 0;
  endtask

  task automatic await_rsp(input int exp_lat, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge ACLK);
      lat++;
      n_aw += int'(AWVALID); n_w += int'(WVALID); n_b += int'(BREADY); n_r += int'(RREADY);
      if (AWVALID) seen_aw = AWADDR;
      if (WVALID) begin seen_wd = WDATA; seen_ws = WSTRB; end
      if (ARVALID) seen_ar = ARADDR;
      got = rsp_valid;
    end
    chk("rsp_seen", got, 1);
    if (got) begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
      if (exp_lat != 0) chk("latency", lat, exp_lat);
    end
    @(negedge ACLK);
    chk("pulse_one_cycle", rsp_valid, 0);
    chk("ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; aw_never = 0; r_data = 0; model = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr_strb", {AWADDR, ARADDR, WSTRB}, 0);
    chk("rst_wdata", WDATA, 0);
    ARESETn = 1;
    #1 chk("release_cmd_ready", cmd_ready, 1);
    @(negedge ACLK);
    // zero-wait write
    issue(1, 4'h4, 32'hDEADBEEF, 4'hF, 0);
    await_rsp(4, 20);
    chk("w1_aw_cycles", n_aw, 1);
    chk("w1_w_cycles", n_w, 1);
    chk("w1_bready_cycles", n_b, 1);
    chk("w1_awaddr", seen_aw, 4'h4);
    chk("w1_wdata", seen_wd, 32'hDEADBEEF);
    chk("w1_wstrb", seen_ws, 4'hF);
    // read with RVALID arriving in the third RREADY cycle
    r_dly = 2;
    issue(0, 4'h8, 32'h12345678, 4'h0, 0);
    await_rsp(6, 20);
    chk("r1_rready_cycles", n_r, 3);
    chk("r1_araddr", seen_ar, 4'h8);
    // write with WREADY two cycles after AWREADY
    r_dly = 0; w_dly = 2;
    issue(1, 4'hA, 32'hA5A50F0F, 4'h3, 0);
    await_rsp(6, 20);
    chk("w2_aw_cycles", n_aw, 1);
    chk("w2_w_cycles", n_w, 3);
    chk("w2_awaddr", seen_aw, 4'hA);
    chk("w2_wdata", seen_wd, 32'hA5A50F0F);
    chk("w2_wstrb", seen_ws, 4'h3);
    // back-to-back read, accepted the cycle after the previous rsp_valid
    w_dly = 0;
    issue(0, 4'hC, 32'hCAFEF00D, 4'h0, 0);
    await_rsp(4, 20);
    chk("r2_araddr", seen_ar, 4'hC);
    // reset while waiting in the read-data phase
    r_dly = 100;
    issue(0, 4'h8, 32'h55AA55AA, 4'h0, 0);
    for (int i = 0; i < 10 && !RREADY; i++) @(negedge ACLK);
    chk("in_rdata_phase", RREADY, 1);
    #2 ARESETn = 0;
    #1;
    chk("mid_rst_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_err, cmd_ready}, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_addr", {AWADDR, ARADDR, WSTRB}, 0);
    n_rsp = 0;
    repeat (3) begin @(negedge ACLK); n_rsp += int'(rsp_valid); end
    ARESETn = 1;
    sb.delete();
    model = 0; r_dly = 0;
    repeat (3) begin @(negedge ACLK); n_rsp += int'(rsp_valid); end
    chk("dropped_no_rsp", n_rsp, 0);
    chk("post_rst_ready", cmd_ready, 1);
    issue(0, 4'h8, 32'h0BADF00D, 4'h0, 0);
    await_rsp(4, 20);
    // slave that never raises AWREADY
    aw_never = 1;
`ifdef AXIL_TIMEOUT_EN
    issue(1, 4'h2, 32'h11112222, 4'hF, 1);
    await_rsp(18, 40);
    chk("to_aw_cycles", n_aw, 16);
    chk("to_w_cycles", n_w, 1);
`else
    issue(1, 4'h2, 32'h11112222, 4'hF, 0);
    n_rsp = 0;
    repeat (40) begin @(negedge ACLK); n_rsp += int'(rsp_valid); end
    chk("stall_no_rsp", n_rsp, 0);
    chk("stall_awvalid_held", AWVALID, 1);
    chk("stall_awaddr", AWADDR, 4'h2);
    aw_never = 0;
    await_rsp(0, 20);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
